// File: rtl/cpu_pkg.sv
// Shared widths, opcode constants and ID/EX stall FSM encoding.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int OPCODE_W_DEF   = 5;
    localparam int IMM_W_DEF      = 16;
    localparam int CNT_W          = 16;

    typedef enum logic [4:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_SUB = 5'd2,
        OP_LD  = 5'd3,
        OP_ST  = 5'd4
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand select between register-file read data and the write-back result.
module fwd_mux #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] data
);

    assign data = sel ? wb_data : rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock (two bubbles) and WB forwarding.
// Optional bubble statistics counter enabled by defining ID_EX_STATS_EN.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
    parameter int REG_ADDRESS_LENGTH = REG_ADDR_W_DEF,
    parameter int OPCODE_LENGTH      = OPCODE_W_DEF,
    parameter int IMM_WIDTH          = IMM_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall_in,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rA,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rB,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rD,
    input  logic [OPCODE_LENGTH-1:0]      id_opcode,
    input  logic [IMM_WIDTH-1:0]          id_imm,
    input  logic                          id_reg_wr,
    input  logic                          id_mem_rd,
    input  logic                          id_mem_wr,
    input  logic [DATA_WIDTH-1:0]         rf_rA_data,
    input  logic [DATA_WIDTH-1:0]         rf_rB_data,
    input  logic                          fwd_rA,
    input  logic                          fwd_rB,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    output logic                          load_stall,
    output logic                          ex_valid,
    output logic                          ex_reg_wr,
    output logic                          ex_mem_rd,
    output logic                          ex_mem_wr,
    output logic [DATA_WIDTH-1:0]         ex_opA,
    output logic [DATA_WIDTH-1:0]         ex_opB,
    output logic [REG_ADDRESS_LENGTH-1:0] ex_rD,
    output logic [OPCODE_LENGTH-1:0]      ex_opcode,
    output logic [IMM_WIDTH-1:0]          ex_imm,
    output logic [CNT_W-1:0]              bubble_cnt
);

    state_e                state;
    logic                  hazard;
    logic                  bubble;
    logic                  capture;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
        .sel     (fwd_rA),
        .rf_data (rf_rA_data),
        .wb_data (wb_data),
        .data    (op_a)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
        .sel     (fwd_rB),
        .rf_data (rf_rB_data),
        .wb_data (wb_data),
        .data    (op_b)
    );

    // A load in EX whose destination is read by ID; r0 is never a real dependency.
    assign hazard = id_valid & ex_valid & ex_mem_rd & (ex_rD != '0)
                  & ((id_rA == ex_rD) | (id_rB == ex_rD));

    assign load_stall = ((state == ST_IDLE) & hazard) | (state == ST_WAIT);

    // A bubble only enters EX when the pipeline actually advances.
    assign bubble  = load_stall & ~stall_in;
    assign capture = ~flush & ~bubble & ~stall_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (hazard && !flush && !stall_in) state <= ST_WAIT;
                ST_WAIT: if (flush || !stall_in)            state <= ST_IDLE;
                default:                                    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_reg_wr <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            ex_rD     <= '0;
        end else if (flush || bubble) begin
            ex_valid  <= 1'b0;
            ex_reg_wr <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            ex_rD     <= '0;
        end else if (!stall_in) begin
            ex_valid  <= id_valid;
            ex_reg_wr <= id_reg_wr;
            ex_mem_rd <= id_mem_rd;
            ex_mem_wr <= id_mem_wr;
            ex_rD     <= id_rD;
        end
    end

    // Data fields are don't-care in a squashed slot, so they simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_opA    <= '0;
            ex_opB    <= '0;
            ex_opcode <= OPCODE_LENGTH'(OP_NOP);
            ex_imm    <= '0;
        end else if (capture) begin
            ex_opA    <= op_a;
            ex_opB    <= op_b;
            ex_opcode <= id_opcode;
            ex_imm    <= id_imm;
        end
    end

`ifdef ID_EX_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bubble && !flush) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign bubble_cnt = cnt;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture/forward table plus load-use, flush, hold and reset sequences.
module tb_id_ex_stage;

`ifdef ID_EX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in, flush, id_valid;
    logic [4:0]  id_rA, id_rB, id_rD, id_opcode;
    logic [15:0] id_imm;
    logic        id_reg_wr, id_mem_rd, id_mem_wr;
    logic [63:0] rf_rA_data, rf_rB_data, wb_data;
    logic        fwd_rA, fwd_rB;
    logic        load_stall, ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr;
    logic [63:0] ex_opA, ex_opB;
    logic [4:0]  ex_rD, ex_opcode;
    logic [15:0] ex_imm, bubble_cnt;

    int errors = 0;
    int checks = 0;
    int exp_bub = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
        .id_valid(id_valid), .id_rA(id_rA), .id_rB(id_rB), .id_rD(id_rD),
        .id_opcode(id_opcode), .id_imm(id_imm), .id_reg_wr(id_reg_wr),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .rf_rA_data(rf_rA_data), .rf_rB_data(rf_rB_data),
        .fwd_rA(fwd_rA), .fwd_rB(fwd_rB), .wb_data(wb_data),
        .load_stall(load_stall), .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_opA(ex_opA),
        .ex_opB(ex_opB), .ex_rD(ex_rD), .ex_opcode(ex_opcode), .ex_imm(ex_imm),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  ra, rb, rd, op;
        logic [15:0] imm;
        logic        reg_wr, mem_rd, mem_wr;
        logic [63:0] rfa, rfb;
        logic        fa, fb;
        logic [63:0] wb;
        logic        exp_ls;
        logic [63:0] exp_a, exp_b;
    } vec_t;

    function automatic vec_t mk(int valid, int ra, int rb, int rd, int op, int imm,
                                int rw, int mr, int mw, logic [63:0] rfa, logic [63:0] rfb,
                                int fa, int fb, logic [63:0] wb, int ls,
                                logic [63:0] ea, logic [63:0] eb);
        vec_t v;
        v.valid = 1'(valid); v.ra = 5'(ra); v.rb = 5'(rb); v.rd = 5'(rd);
        v.op = 5'(op); v.imm = 16'(imm);
        v.reg_wr = 1'(rw); v.mem_rd = 1'(mr); v.mem_wr = 1'(mw);
        v.rfa = rfa; v.rfb = rfb; v.fa = 1'(fa); v.fb = 1'(fb); v.wb = wb;
        v.exp_ls = 1'(ls); v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        id_valid = v.valid; id_rA = v.ra; id_rB = v.rb; id_rD = v.rd;
        id_opcode = v.op; id_imm = v.imm;
        id_reg_wr = v.reg_wr; id_mem_rd = v.mem_rd; id_mem_wr = v.mem_wr;
        rf_rA_data = v.rfa; rf_rB_data = v.rfb;
        fwd_rA = v.fa; fwd_rB = v.fb; wb_data = v.wb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_capture(string tag, vec_t v);
        check({tag, ".ex_valid"},  64'(ex_valid),  64'(v.valid));
        check({tag, ".ex_reg_wr"}, 64'(ex_reg_wr), 64'(v.reg_wr));
        check({tag, ".ex_mem_rd"}, 64'(ex_mem_rd), 64'(v.mem_rd));
        check({tag, ".ex_mem_wr"}, 64'(ex_mem_wr), 64'(v.mem_wr));
        check({tag, ".ex_rD"},     64'(ex_rD),     64'(v.rd));
        check({tag, ".ex_opcode"}, 64'(ex_opcode), 64'(v.op));
        check({tag, ".ex_imm"},    64'(ex_imm),    64'(v.imm));
        check({tag, ".ex_opA"},    ex_opA,         v.exp_a);
        check({tag, ".ex_opB"},    ex_opB,         v.exp_b);
    endtask

    task automatic check_bubble_slot(string tag, logic exp_ls);
        check({tag, ".ex_valid"},   64'(ex_valid),   64'd0);
        check({tag, ".ex_reg_wr"},  64'(ex_reg_wr),  64'd0);
        check({tag, ".ex_mem_rd"},  64'(ex_mem_rd),  64'd0);
        check({tag, ".ex_rD"},      64'(ex_rD),      64'd0);
        check({tag, ".load_stall"}, 64'(load_stall), 64'(exp_ls));
        check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(STATS ? exp_bub : 0));
    endtask

    task automatic check_all_zero(string tag);
        check({tag, ".ex_valid"},   64'(ex_valid),   64'd0);
        check({tag, ".ex_reg_wr"},  64'(ex_reg_wr),  64'd0);
        check({tag, ".ex_mem_rd"},  64'(ex_mem_rd),  64'd0);
        check({tag, ".ex_mem_wr"},  64'(ex_mem_wr),  64'd0);
        check({tag, ".ex_opA"},     ex_opA,          64'd0);
        check({tag, ".ex_opB"},     ex_opB,          64'd0);
        check({tag, ".ex_rD"},      64'(ex_rD),      64'd0);
        check({tag, ".ex_opcode"},  64'(ex_opcode),  64'd0);
        check({tag, ".ex_imm"},     64'(ex_imm),     64'd0);
        check({tag, ".load_stall"}, 64'(load_stall), 64'd0);
        check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vec_t ld, use1, use2, useb;

        vt[0] = mk(1, 3, 1, 2,  1, 'h0010, 1, 0, 0, 64'h11, 64'h22, 0, 0, 64'h99,   0, 64'h11, 64'h22);
        vt[1] = mk(1, 5, 6, 7,  2, 'h0020, 1, 0, 0, 64'h7,  64'h5,  0, 1, 64'hDEAD, 0, 64'h7,  64'hDEAD);
        vt[2] = mk(1, 1, 2, 0,  3, 'h0030, 1, 1, 0, 64'h1,  64'h2,  1, 0, 64'hBEEF, 0, 64'hBEEF, 64'h2);
        vt[3] = mk(1, 0, 0, 9,  3, 'h0040, 1, 1, 0, 64'h3,  64'h4,  0, 0, 64'h0,    0, 64'h3,  64'h4);
        vt[4] = mk(0, 9, 9, 3,  0, 'h0000, 0, 0, 0, 64'h5,  64'h6,  0, 0, 64'h0,    0, 64'h5,  64'h6);
        vt[5] = mk(1, 3, 4, 0,  4, 'h0050, 0, 0, 1, 64'h8,  64'h9,  1, 1, 64'h1234, 0, 64'h1234, 64'h1234);
        vt[6] = mk(1, 2, 3, 10, 31, 'hFFFF, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h8000_0000_0000_0001, 0, 0, 64'h0, 0,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);

        ld   = mk(1, 1, 2, 4, 3, 'h0004, 1, 1, 0, 64'h40,  64'h8, 0, 0, 64'h0,    0, 64'h40,   64'h8);
        use1 = mk(1, 4, 0, 5, 1, 'h0007, 1, 0, 0, 64'h111, 64'h2, 0, 0, 64'h0,    1, 64'h111,  64'h2);
        use2 = mk(1, 4, 0, 5, 1, 'h0007, 1, 0, 0, 64'h111, 64'h2, 1, 0, 64'hAAAA, 0, 64'hAAAA, 64'h2);
        useb = mk(1, 0, 4, 6, 2, 'h0008, 1, 0, 0, 64'h3,   64'h4, 0, 0, 64'h0,    1, 64'h3,    64'h4);

        rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 64'h0));
        #2;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // Straight-line capture and forwarding table
        for (int i = 0; i < 7; i++) begin
            apply(vt[i]);
            #1;
            check($sformatf("v%0d.load_stall", i), 64'(load_stall), 64'(vt[i].exp_ls));
            step();
            check_capture($sformatf("v%0d", i), vt[i]);
        end

        // Load-use: two bubbles, then capture with WB forwarding
        apply(ld);
        step();
        check_capture("lu.load", ld);
        apply(use1);
        #1;
        check("lu.hazard_ls", 64'(load_stall), 64'd1);
        step();
        exp_bub++;
        check_bubble_slot("lu.bubble1", 1'b1);
        step();
        exp_bub++;
        check_bubble_slot("lu.bubble2", 1'b0);
        apply(use2);
        step();
        check_capture("lu.dep", use2);
        check("lu.bubble_cnt", 64'(bubble_cnt), 64'(STATS ? 2 : 0));

        // Flush while waiting out a load-use stall
        apply(ld);
        step();
        apply(useb);
        #1;
        check("fl.hazard_ls", 64'(load_stall), 64'd1);
        step();
        exp_bub++;
        check_bubble_slot("fl.bubble1", 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check_bubble_slot("fl.after", 1'b0);
        apply(vt[0]);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_bubble_slot("fl.squash", 1'b0);
        step();
        check_capture("fl.recap", vt[0]);

        // Downstream hold on a valid instruction
        apply(vt[1]);
        stall_in = 1'b1;
        step();
        check_capture("hold", vt[0]);
        stall_in = 1'b0;
        step();
        check_capture("hold.release", vt[1]);

        // Downstream hold while in the second stall cycle
        apply(ld);
        step();
        apply(use1);
        step();
        exp_bub++;
        check_bubble_slot("sw.bubble1", 1'b1);
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_bubble_slot($sformatf("sw.hold%0d", k), 1'b1);
        end
        stall_in = 1'b0;
        step();
        exp_bub++;
        check_bubble_slot("sw.bubble2", 1'b0);
        apply(use2);
        step();
        check_capture("sw.dep", use2);

        // Asynchronous reset in the middle of a stall
        apply(ld);
        step();
        apply(use1);
        step();
        exp_bub++;
        check_bubble_slot("rs.bubble1", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_bub = 0;
        check_all_zero("rs.async");
        step();
        check_all_zero("rs.held");
        #3;
        rst_n = 1'b1;
        #1;
        check("rs.release_ls", 64'(load_stall), 64'd0);
        step();
        check_capture("rs.resume", use1);
        check("rs.bubble_cnt", 64'(bubble_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
